// File: rtl/drc_pkg.sv
// rtl/drc_pkg.sv - shared constants and FSM encoding for the DVP pixel capture block
package drc_pkg;

    localparam int DVP_BYTE_W    = 8;
    localparam int CAM_START_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/drc_pxl_capture_if.sv
// rtl/drc_pxl_capture_if.sv - pixel stream bundle (head entry plus valid/ready handshake)
interface drc_pxl_capture_if #(
    parameter int PXL_W = 16
);
    logic [PXL_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             valid;
    logic             ready;

    modport master (output data, sof, eol, valid, input ready);
    modport slave  (input data, sof, eol, valid, output ready);
endinterface

// File: rtl/drc_sync_fifo.sv
// rtl/drc_sync_fifo.sv - pixel FIFO holding {sof, eol, data}; flush empties it in one cycle
module drc_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             wr_sof,
    input  logic             wr_eol,
    output logic             full,
    drc_pxl_capture_if.master rd
);
    localparam int AW = $clog2(DEPTH);

    logic [W+1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W+1:0] head;
    logic         empty;
    logic         pop;
    logic         push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rd.ready;
    // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {wr_sof, wr_eol, wr_data};
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign rd.valid = !empty;
    assign rd.data  = empty ? '0 : head[W-1:0];
    assign rd.sof   = !empty && head[W+1];
    assign rd.eol   = !empty && head[W];

endmodule

// File: rtl/drc_pxl_capture.sv
// rtl/drc_pxl_capture.sv - DVP camera byte capture into 16-bit pixels with sof/eol marking
// Optional statistics outputs line_cnt_o/frame_cnt_o enabled by DRC_CAP_STAT_EN.
module drc_pxl_capture
    import drc_pkg::*;
#(
    parameter int DVP_CAM_CFG_W = 32,
    parameter int PXL_W         = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_i,
    input  logic                     dvp_pclk_i,
    input  logic                     dvp_href_i,
    input  logic                     dvp_vsync_i,
    input  logic [DVP_BYTE_W-1:0]    dvp_d_i,
    output logic [PXL_W-1:0]         pxl_data_o,
    output logic                     pxl_sof_o,
    output logic                     pxl_eol_o,
    output logic                     pxl_valid_o,
    input  logic                     pxl_ready_i,
    output logic                     frame_done_o,
    output logic                     ovf_o
`ifdef DRC_CAP_STAT_EN
    ,
    output logic [11:0]              line_cnt_o,
    output logic [15:0]              frame_cnt_o
`endif
);
    // [0],[1] synchronizer stages, [2] previous synced value for edge detection
    logic [2:0]            pclk_sr, href_sr, vsync_sr;
    logic [DVP_BYTE_W-1:0] d_s1, d_s2;
    logic                  pclk_rise, href_fall, vsync_fall, vsync_rise;
    logic                  cam_start, cfg_unused;
    cap_state_t            state, state_nxt;
    logic                  sof_enter, frame_end;
    logic                  phase, sof_arm, pend_valid, pend_sof;
    logic [DVP_BYTE_W-1:0] hi_byte;
    logic [PXL_W-1:0]      pend_data;
    logic                  cap_en, wr_en, fifo_full, pop;

    drc_pxl_capture_if #(.PXL_W(PXL_W)) head_if ();

    assign cam_start  = dcr_cam_cfg_i[CAM_START_BIT];
    assign cfg_unused = ^dcr_cam_cfg_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sr  <= '0;
            href_sr  <= '0;
            vsync_sr <= '0;
            d_s1     <= '0;
            d_s2     <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], dvp_pclk_i};
            href_sr  <= {href_sr[1:0], dvp_href_i};
            vsync_sr <= {vsync_sr[1:0], dvp_vsync_i};
            d_s1     <= dvp_d_i;
            d_s2     <= d_s1;
        end
    end

    assign pclk_rise  =  pclk_sr[1]  & ~pclk_sr[2];
    assign href_fall  = ~href_sr[1]  &  href_sr[2];
    assign vsync_fall = ~vsync_sr[1] &  vsync_sr[2];
    assign vsync_rise =  vsync_sr[1] & ~vsync_sr[2];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sof_enter = 1'b0;
        frame_end = 1'b0;
        if (!cam_start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = ST_WAIT_SOF;
                ST_WAIT_SOF: if (vsync_fall) begin
                    state_nxt = ST_ACTIVE;
                    sof_enter = 1'b1;
                end
                ST_ACTIVE:   if (vsync_rise) begin
                    state_nxt = ST_WAIT_SOF;
                    frame_end = 1'b1;
                end
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    assign cap_en = (state == ST_ACTIVE) && pclk_rise && href_sr[1];
    // the finished pixel waits one slot so the next event decides whether it is eol
    assign wr_en  = pend_valid && ((cap_en && phase) || href_fall);

    always_ff @(posedge clk) begin
        if (rst || state_nxt != ST_ACTIVE) begin
            phase      <= 1'b0;
            sof_arm    <= 1'b0;
            pend_valid <= 1'b0;
            pend_sof   <= 1'b0;
            pend_data  <= '0;
            hi_byte    <= '0;
        end else begin
            if (sof_enter) sof_arm <= 1'b1;
            if (href_fall) begin
                phase      <= 1'b0;
                pend_valid <= 1'b0;
            end else if (cap_en) begin
                if (!phase) begin
                    hi_byte <= d_s2;
                    phase   <= 1'b1;
                end else begin
                    phase      <= 1'b0;
                    pend_valid <= 1'b1;
                    pend_data  <= PXL_W'({hi_byte, d_s2});
                    pend_sof   <= sof_arm;
                    sof_arm    <= 1'b0;
                end
            end
        end
    end

    drc_sync_fifo #(.W(PXL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (!cam_start),
        .wr_en   (wr_en),
        .wr_data (pend_data),
        .wr_sof  (pend_sof),
        .wr_eol  (href_fall),
        .full    (fifo_full),
        .rd      (head_if)
    );

    assign head_if.ready = pxl_ready_i;
    assign pxl_data_o    = head_if.data;
    assign pxl_sof_o     = head_if.sof;
    assign pxl_eol_o     = head_if.eol;
    assign pxl_valid_o   = head_if.valid;
    assign pop           = pxl_valid_o && pxl_ready_i;

    always_ff @(posedge clk) begin
        if (rst) frame_done_o <= 1'b0;
        else     frame_done_o <= frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst || !cam_start)                ovf_o <= 1'b0;
        else if (wr_en && fifo_full && !pop)  ovf_o <= 1'b1;
    end

`ifdef DRC_CAP_STAT_EN
    always_ff @(posedge clk) begin
        if (rst || !cam_start) begin
            line_cnt_o  <= '0;
            frame_cnt_o <= '0;
        end else begin
            if (sof_enter)
                line_cnt_o <= '0;
            else if (pend_valid && href_fall && line_cnt_o != 12'hFFF)
                line_cnt_o <= line_cnt_o + 12'd1;
            if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drc_pxl_capture.sv
// tb/tb_drc_pxl_capture.sv - self-checking bench for drc_pxl_capture
module tb_drc_pxl_capture;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        int          nbytes;
        logic [47:0] bytes;
        int          npix;
        logic [53:0] px;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] dcr_cam_cfg_i;
    logic        dvp_pclk_i, dvp_href_i, dvp_vsync_i;
    logic [7:0]  dvp_d_i;
    logic [15:0] pxl_data_o;
    logic        pxl_sof_o, pxl_eol_o, pxl_valid_o, pxl_ready_i;
    logic        frame_done_o, ovf_o;
`ifdef DRC_CAP_STAT_EN
    logic [11:0] line_cnt_o;
    logic [15:0] frame_cnt_o;
`endif

    drc_pxl_capture_if #(.PXL_W(16)) mon_if ();

    drc_pxl_capture dut (
        .clk           (clk),
        .rst           (rst),
        .dcr_cam_cfg_i (dcr_cam_cfg_i),
        .dvp_pclk_i    (dvp_pclk_i),
        .dvp_href_i    (dvp_href_i),
        .dvp_vsync_i   (dvp_vsync_i),
        .dvp_d_i       (dvp_d_i),
        .pxl_data_o    (pxl_data_o),
        .pxl_sof_o     (pxl_sof_o),
        .pxl_eol_o     (pxl_eol_o),
        .pxl_valid_o   (pxl_valid_o),
        .pxl_ready_i   (pxl_ready_i),
        .frame_done_o  (frame_done_o),
        .ovf_o         (ovf_o)
`ifdef DRC_CAP_STAT_EN
        ,
        .line_cnt_o    (line_cnt_o),
        .frame_cnt_o   (frame_cnt_o)
`endif
    );

    assign mon_if.data  = pxl_data_o;
    assign mon_if.sof   = pxl_sof_o;
    assign mon_if.eol   = pxl_eol_o;
    assign mon_if.valid = pxl_valid_o;
    assign mon_if.ready = pxl_ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [17:0] got [$];
    logic [17:0] exp_q [$];
    logic        m_first;
    bit          mon_en = 0;
    bit          rnd_ready = 0;
    int          fd_cnt = 0;
    int          fd_run = 0;
    int          fd_maxrun = 0;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        dvp_d_i = b;
        tick(3);
        dvp_pclk_i = 1'b1;
        tick(4);
        dvp_pclk_i = 1'b0;
        tick(1);
    endtask

    task automatic send_line(input bq_t b);
        dvp_href_i = 1'b1;
        tick(2);
        foreach (b[i]) send_byte(b[i]);
        tick(2);
        dvp_href_i = 1'b0;
        tick(6);
    endtask

    task automatic start_frame();
        dvp_vsync_i = 1'b1;
        tick(4);
        dvp_vsync_i = 1'b0;
        tick(4);
        m_first = 1'b1;
    endtask

    task automatic end_frame();
        dvp_vsync_i = 1'b1;
        tick(6);
    endtask

    // reference: bytes pair up in order, first pixel of the frame is sof, last pair of a line is eol
    task automatic model_line(input bq_t b);
        int np;
        np = b.size() / 2;
        for (int k = 0; k < np; k++) begin
            exp_q.push_back({m_first, (k == np - 1), b[2*k], b[2*k+1]});
            m_first = 1'b0;
        end
    endtask

    task automatic wait_drain(input int n);
        for (int c = 0; c < 3000 && got.size() < n; c++) tick(1);
        tick(10);
    endtask

    task automatic compare_model(input string name, input int n);
        check({name, "_count"}, got.size(), n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_px%0d", name, k),
                  (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    endtask

    function automatic bq_t ramp(input int n, input logic [7:0] base);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        return q;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mon_if.valid && mon_if.ready) got.push_back({mon_if.sof, mon_if.eol, mon_if.data});
                if (frame_done_o) begin
                    fd_cnt++;
                    fd_run++;
                    if (fd_run > fd_maxrun) fd_maxrun = fd_run;
                end else begin
                    fd_run = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) pxl_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t lb;
        int  fd0;

        vecs[0] = '{4, 48'h1234_5678_0000, 2, {18'h21234, 18'h15678, 18'h00000}};
        vecs[1] = '{5, 48'h9ABC_DEF0_1100, 2, {18'h29ABC, 18'h1DEF0, 18'h00000}};
        vecs[2] = '{2, 48'hAA55_0000_0000, 1, {18'h3AA55, 18'h00000, 18'h00000}};
        vecs[3] = '{1, 48'h7700_0000_0000, 0, {18'h00000, 18'h00000, 18'h00000}};
        vecs[4] = '{6, 48'h0102_0304_0506, 3, {18'h20102, 18'h00304, 18'h10506}};
        vecs[5] = '{3, 48'hFF00_8000_0000, 1, {18'h3FF00, 18'h00000, 18'h00000}};

        rst = 1'b1;
        dcr_cam_cfg_i = 32'h0;
        dvp_pclk_i = 1'b0;
        dvp_href_i = 1'b0;
        dvp_vsync_i = 1'b0;
        dvp_d_i = 8'h0;
        pxl_ready_i = 1'b1;
        m_first = 1'b1;
        tick(3);
        check("rst_valid", pxl_valid_o, 0);
        check("rst_data", pxl_data_o, 0);
        check("rst_sof", pxl_sof_o, 0);
        check("rst_eol", pxl_eol_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst = 1'b0;
        dcr_cam_cfg_i = 32'hA5A5_0001;
        mon_en = 1;
        tick(3);

        // two-line frame: frame_done exactly one cycle, stats after first frame since start
        got.delete(); exp_q.delete();
        start_frame();
        for (int l = 0; l < 2; l++) begin
            lb = ramp(4, 8'(8'h40 + 8'(16 * l)));
            model_line(lb);
            send_line(lb);
        end
        fd0 = fd_cnt;
        fd_maxrun = 0;
        end_frame();
        wait_drain(exp_q.size());
        compare_model("two_line", exp_q.size());
        check("two_line_frame_done_cnt", fd_cnt - fd0, 1);
        check("two_line_frame_done_width", fd_maxrun, 1);
`ifdef DRC_CAP_STAT_EN
        check("stat_line_cnt", line_cnt_o, 2);
        check("stat_frame_cnt", frame_cnt_o, 1);
`endif

        // table-driven single-line frames
        for (int v = 0; v < 6; v++) begin
            lb.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) lb.push_back(vecs[v].bytes[47-8*i -: 8]);
            got.delete();
            fd0 = fd_cnt;
            start_frame();
            send_line(lb);
            end_frame();
            wait_drain(vecs[v].npix);
            check($sformatf("vec%0d_count", v), got.size(), vecs[v].npix);
            for (int k = 0; k < vecs[v].npix; k++)
                check($sformatf("vec%0d_px%0d", v, k),
                      (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(vecs[v].px[53-18*k -: 18]));
            check($sformatf("vec%0d_frame_done", v), fd_cnt - fd0, 1);
        end

        // overflow: six pixels into a four-deep FIFO while stalled
        pxl_ready_i = 1'b0;
        got.delete(); exp_q.delete();
        start_frame();
        lb = ramp(12, 8'h10);
        model_line(lb);
        send_line(lb);
        tick(4);
        check("ovf_valid_held", pxl_valid_o, 1);
        check("ovf_set", ovf_o, 1);
        check("ovf_head_stable", pxl_data_o, 32'(exp_q[0][15:0]));
        check("ovf_no_pop", got.size(), 0);
        pxl_ready_i = 1'b1;
        wait_drain(4);
        compare_model("ovf_drain", 4);
        check("ovf_sticky", ovf_o, 1);
        check("ovf_fifo_empty", pxl_valid_o, 0);
        end_frame();

        // cam_start drops mid-line with FIFO occupied and overflow flagged
        pxl_ready_i = 1'b0;
        start_frame();
        dvp_href_i = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
        tick(2);
        check("stop_pre_valid", pxl_valid_o, 1);
        check("stop_pre_ovf", ovf_o, 1);
        fd0 = fd_cnt;
        dcr_cam_cfg_i = 32'hA5A5_0000;
        tick(1);
        check("stop_valid", pxl_valid_o, 0);
        check("stop_ovf", ovf_o, 0);
        dvp_href_i = 1'b0;
        tick(6);
        end_frame();
        check("stop_no_frame_done", fd_cnt - fd0, 0);
        // restart with vsync held high: lines before the next vsync fall are ignored
        dcr_cam_cfg_i = 32'h0000_0001;
        pxl_ready_i = 1'b1;
        tick(3);
        got.delete();
        send_line(ramp(4, 8'h20));
        tick(4);
        check("prestart_ignored", got.size(), 0);

        // reset in ACTIVE with a full, overflowed FIFO
        pxl_ready_i = 1'b0;
        start_frame();
        send_line(ramp(12, 8'h60));
        check("rst2_pre_valid", pxl_valid_o, 1);
        rst = 1'b1;
        tick(1);
        check("rst2_valid", pxl_valid_o, 0);
        check("rst2_data", pxl_data_o, 0);
        check("rst2_sof", pxl_sof_o, 0);
        check("rst2_eol", pxl_eol_o, 0);
        check("rst2_frame_done", frame_done_o, 0);
        check("rst2_ovf", ovf_o, 0);
        rst = 1'b0;
        pxl_ready_i = 1'b1;
        tick(3);

        // randomized frames against the reference model with random backpressure
        for (int f = 0; f < 6; f++) begin
            int nl;
            got.delete(); exp_q.delete();
            rnd_ready = 1;
            fd0 = fd_cnt;
            start_frame();
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                int nb;
                lb.delete();
                nb = $urandom_range(0, 7);
                for (int i = 0; i < nb; i++) lb.push_back(8'($urandom));
                model_line(lb);
                send_line(lb);
            end
            end_frame();
            wait_drain(exp_q.size());
            rnd_ready = 0;
            tick(1);
            pxl_ready_i = 1'b1;
            tick(2);
            compare_model($sformatf("rnd%0d", f), exp_q.size());
            check($sformatf("rnd%0d_ovf", f), ovf_o, 0);
            check($sformatf("rnd%0d_frame_done", f), fd_cnt - fd0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/drc_pxl_capture.md
DRC_PXL_CAPTURE -- requirements
Module: drc_pxl_capture

Interface
REQ-001 SHALL have parameter DVP_CAM_CFG_W, default 32, width of the DVP camera configuration register.
REQ-002 SHALL have parameter PXL_W, default 16, width of the assembled pixel (two DVP bytes).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port dcr_cam_cfg_i  in  DVP_CAM_CFG_W  configuration register; bit 0 = cam_start.
REQ-007 SHALL have ports dvp_pclk_i, dvp_href_i, dvp_vsync_i  in  1 each  asynchronous camera timing inputs.
REQ-008 SHALL have port dvp_d_i  in  8  asynchronous camera data byte.
REQ-009 SHALL have ports pxl_data_o  out  PXL_W, pxl_sof_o  out  1, pxl_eol_o  out  1, forming the FIFO head.
REQ-010 SHALL have ports pxl_valid_o  out  1, pxl_ready_i  in  1  forming the output handshake.
REQ-011 SHALL have ports frame_done_o  out  1  (1-cycle pulse) and ovf_o  out  1  (sticky overflow).

Function
REQ-012 SHALL pass pclk, href, vsync and d through two flop stages each, all with equal delay.
REQ-013 SHALL detect a pclk rising edge as synced pclk=1 with previous synced value 0; a byte is sampled only on that cycle.
REQ-014 SHALL run FSM IDLE -> WAIT_SOF -> ACTIVE: IDLE->WAIT_SOF when cam_start=1; WAIT_SOF->ACTIVE on synced vsync falling edge; ACTIVE->WAIT_SOF on synced vsync rising edge; any state->IDLE when cam_start=0.
REQ-015 SHALL, in ACTIVE with href=1 on a pclk edge, store byte 0 as pixel[15:8] and byte 1 as pixel[7:0], then write the pixel to the FIFO.
REQ-016 SHALL reset the byte phase to 0 on every href falling edge and discard an unpaired trailing byte.
REQ-017 SHALL set pxl_sof_o on the first pixel after entering ACTIVE and pxl_eol_o on the last pixel before each href falling edge (carried in the FIFO entry alongside data).
REQ-018 SHALL, for eol marking, hold each completed pixel one pixel-slot before writing; flush it with eol=1 when href falls.
REQ-019 SHALL pulse frame_done_o for one cycle on the ACTIVE->WAIT_SOF transition (not on ACTIVE->IDLE).
REQ-020 SHALL pop the FIFO when pxl_valid_o & pxl_ready_i; pxl_valid_o = FIFO not empty; head data stable while valid & !ready.
REQ-021 SHALL, on a write to a full FIFO, drop the incoming pixel and set ovf_o; simultaneous write and pop when full SHALL succeed without overflow.
REQ-022 SHALL clear ovf_o only by reset or cam_start=0.
REQ-023 SHALL, on cam_start falling mid-frame, flush the FIFO, clear the pending pixel and byte phase in the next cycle.
REQ-024 SHALL ignore frame timing before the first vsync falling edge (partial frame after start never captured).

Reset
REQ-025 SHALL on rst=1: FSM=IDLE, FIFO empty, pxl_valid_o=0, pxl_data_o=0, pxl_sof_o=0, pxl_eol_o=0, frame_done_o=0, ovf_o=0, synchronizers=0, byte phase=0.
REQ-026 SHALL honour rst in the same cycle regardless of state or handshake.

Configuration
REQ-027 SHALL, when DRC_CAP_STAT_EN is defined, add outputs line_cnt_o [11:0] (lines in current frame, cleared at SOF, +1 per eol pixel, saturating at 4095) and frame_cnt_o [15:0] (+1 per frame_done_o, wrapping, cleared by reset/cam_start=0).
REQ-028 SHALL, when DRC_CAP_STAT_EN is undefined, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place FSM state encoding, DVP byte width (8) and cam_start bit index (0) in shared package drc_pkg.
REQ-030 SHALL implement the buffer as sub-module drc_sync_fifo (data+sof+eol entry, full/empty, flush input).

Verification
REQ-031 SHALL test: start=1, vsync falling, one line href of 4 bytes 0x12,0x34,0x56,0x78, ready=1 -> pixels 0x1234 (sof=1), 0x5678 (eol=1).
REQ-032 SHALL test: line of 5 bytes -> 2 pixels, last byte discarded, eol on second pixel.
REQ-033 SHALL test: ready=0 over 6 pixels, FIFO_DEPTH=4 -> 4 pixels held, ovf_o=1; ready=1 -> those 4 delivered in order.
REQ-034 SHALL test: vsync rising after 2 lines -> frame_done_o high exactly 1 cycle; with DRC_CAP_STAT_EN line_cnt_o=2, frame_cnt_o=1.
REQ-035 SHALL test: cam_start=0 mid-line -> FSM IDLE, pxl_valid_o=0 next cycle, ovf_o=0, no frame_done_o.
REQ-036 SHALL test: rst=1 during ACTIVE with FIFO non-empty -> all outputs at reset values next cycle.
